// File: rtl/memory_tile_wb_arbiter.sv
// memory_tile_wb_arbiter: round-robin Wishbone B3 arbiter sharing one memory slave between PORTS masters.
// Define OPTIMSOC_MEMTILE_ARB_TIMEOUT_EN to compile in the hung-slave watchdog (TIMEOUT wait cycles).
module memory_tile_wb_arbiter #(
    parameter int PORTS   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PORTS*32-1:0] m_adr_i,
    input  logic [PORTS*32-1:0] m_dat_i,
    input  logic [PORTS*4-1:0]  m_sel_i,
    input  logic [PORTS-1:0]    m_we_i,
    input  logic [PORTS-1:0]    m_cyc_i,
    input  logic [PORTS-1:0]    m_stb_i,
    input  logic [PORTS*3-1:0]  m_cti_i,
    input  logic [PORTS*2-1:0]  m_bte_i,
    output logic [PORTS-1:0]    m_ack_o,
    output logic [PORTS-1:0]    m_err_o,
    output logic [PORTS-1:0]    m_rty_o,
    output logic [31:0]         m_dat_o,
    output logic [31:0]         s_adr_o,
    output logic [31:0]         s_dat_o,
    output logic [3:0]          s_sel_o,
    output logic                s_we_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic [2:0]          s_cti_o,
    output logic [1:0]          s_bte_o,
    input  logic                s_ack_i,
    input  logic                s_err_i,
    input  logic                s_rty_i,
    input  logic [31:0]         s_dat_i
);
    localparam int GW = $clog2(PORTS);

    logic               busy_q, busy_d;
    logic [GW-1:0]      grant_q, grant_d, last_q, last_d, win;
    logic [31:0]        adr [PORTS];
    logic [31:0]        dat [PORTS];
    logic [3:0]         sel [PORTS];
    logic [2:0]         cti [PORTS];
    logic [1:0]         bte [PORTS];
    logic [2*PORTS-1:0] req2;
    logic [PORTS-1:0]   onehot;
    logic               gcyc, act, timeout;
    int                 off, nxt;

    for (genvar g = 0; g < PORTS; g++) begin : g_unpack
        assign adr[g] = m_adr_i[g*32+:32];
        assign dat[g] = m_dat_i[g*32+:32];
        assign sel[g] = m_sel_i[g*4+:4];
        assign cti[g] = m_cti_i[g*3+:3];
        assign bte[g] = m_bte_i[g*2+:2];
    end

    // Rotate requests so bit i is port last+i; the lowest set bit in 1..PORTS wins.
    assign req2 = {m_cyc_i, m_cyc_i} >> last_q;

    always_comb begin
        off = 0;
        for (int i = PORTS; i >= 1; i--)
            if (req2[i]) off = i;
        nxt = int'(last_q) + off;
        win = GW'(nxt >= PORTS ? nxt - PORTS : nxt);
    end

    assign gcyc = m_cyc_i[grant_q];

    always_comb begin
        busy_d  = busy_q;
        grant_d = grant_q;
        last_d  = last_q;
        if (!busy_q || !gcyc) begin
            busy_d  = |m_cyc_i;
            grant_d = |m_cyc_i ? win : grant_q;
            last_d  = |m_cyc_i ? win : last_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q  <= 1'b0;
            grant_q <= '0;
            last_q  <= GW'(PORTS - 1);
        end else begin
            busy_q  <= busy_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

`ifdef OPTIMSOC_MEMTILE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wd_q, wd_d;

    assign timeout = busy_q & gcyc & (wd_q == CW'(TIMEOUT));
    assign wd_d    = (s_stb_o & ~(s_ack_i | s_err_i | s_rty_i)) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) wd_q <= '0;
        else      wd_q <= wd_d;
    end
`else
    assign timeout = 1'b0 & (TIMEOUT > 0);
`endif

    assign act     = busy_q & gcyc & ~timeout;
    assign onehot  = PORTS'(1) << grant_q;
    assign s_cyc_o = act;
    assign s_stb_o = act & m_stb_i[grant_q];
    assign s_adr_o = busy_q ? adr[grant_q] : '0;
    assign s_dat_o = busy_q ? dat[grant_q] : '0;
    assign s_sel_o = busy_q ? sel[grant_q] : '0;
    assign s_we_o  = busy_q & m_we_i[grant_q];
    assign s_cti_o = busy_q ? cti[grant_q] : '0;
    assign s_bte_o = busy_q ? bte[grant_q] : '0;
    assign m_ack_o = (s_ack_i & act) ? onehot : '0;
    assign m_err_o = ((s_err_i & act) | timeout) ? onehot : '0;
    assign m_rty_o = (s_rty_i & act) ? onehot : '0;
    assign m_dat_o = s_dat_i;
endmodule
